nco_phase_gen: RTL and testbench

//  Phase-accumulator source driving the NCO angle input: emits a burst of cfg_count angle words, stepping by
//  a fractional frequency word, as a valid/ready stream in the packed angle format the NCO consumes.

---
 rtl/nco_phase_gen.sv | 113 +++++++++++
 tb/tb_nco_phase_gen.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_phase_gen.sv
// Phase-accumulator angle source: emits a burst of cfg_count angle words on a valid/ready stream,
// stepping a fractional accumulator by cfg_freq per accepted word.
module nco_phase_gen #(
    parameter int unsigned ANGLE_W = 16,
    parameter int unsigned FRAC_W  = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ANGLE_W+FRAC_W-1:0]  cfg_freq,
    input  logic [ANGLE_W-1:0]         cfg_phase0,
    input  logic [CNT_W-1:0]           cfg_count,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [31:0]                i_data,
    output logic                       i_valid,
    input  logic                       i_ready
);

    localparam int unsigned ACC_W = ANGLE_W + FRAC_W;
    localparam int unsigned PAD_W = 32 - ANGLE_W;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_freq;
    logic [CNT_W-1:0]   r_rem;
    logic               r_valid;
    logic               r_done;
    logic               r_aborted;

    logic               w_hs;
    logic               w_last;
    logic [ACC_W-1:0]   w_acc_next;

    assign w_hs       = r_valid & i_ready;
    assign w_last     = (r_rem == CNT_W'(1));
    assign w_acc_next = r_acc + r_freq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_acc     <= '0;
            r_freq    <= '0;
            r_rem     <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // start has priority over abort; abort is meaningless here
                    if (start) begin
                        r_freq    <= cfg_freq;
                        r_acc     <= {cfg_phase0, {FRAC_W{1'b0}}};
                        r_rem     <= cfg_count;
                        r_aborted <= 1'b0;
                        if (cfg_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= StRun;
                            r_valid <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (w_hs) begin
                        r_acc <= w_acc_next;
                        r_rem <= r_rem - CNT_W'(1);
                    end
                    if (w_hs && w_last) begin
                        r_state <= StIdle;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (abort) begin
                        if (w_hs || !r_valid) begin
                            r_state   <= StIdle;
                            r_valid   <= 1'b0;
                            r_done    <= 1'b1;
                            r_aborted <= 1'b1;
                        end else begin
                            // a stalled word was already offered; it must still be accepted
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (w_hs) begin
                        r_acc     <= w_acc_next;
                        r_rem     <= r_rem - CNT_W'(1);
                        r_state   <= StIdle;
                        r_valid   <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy    = (r_state != StIdle);
    assign done    = r_done;
    assign aborted = r_aborted;
    assign i_valid = r_valid;
    assign i_data  = {r_acc[ACC_W-1 -: ANGLE_W], {PAD_W{1'b0}}};

endmodule

// File: tb/tb_nco_phase_gen.sv
// Scoreboard bench for nco_phase_gen: expected angles are queued at start and popped on handshake.
module tb_nco_phase_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_freq;
    logic [15:0] cfg_phase0;
    logic [15:0] cfg_count;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] i_data;
    logic        i_valid;
    logic        i_ready;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    nco_phase_gen #(
        .ANGLE_W (16),
        .FRAC_W  (16),
        .CNT_W   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_freq   (cfg_freq),
        .cfg_phase0 (cfg_phase0),
        .cfg_count  (cfg_count),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_ready    (i_ready)
    );

    task automatic do_start(input logic [31:0] f, input logic [15:0] p, input logic [15:0] c);
        @(negedge clk);
        cfg_freq   = f;
        cfg_phase0 = p;
        cfg_count  = c;
        start      = 1'b1;
    endtask

    // Scramble config after the start cycle; the burst must not notice.
    task automatic scramble_cfg;
        start      = 1'b0;
        cfg_freq   = $urandom;
        cfg_phase0 = 16'($urandom);
        cfg_count  = 16'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; i_ready = 1'b1;
        cfg_freq = '0; cfg_phase0 = '0; cfg_count = '0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, aborted, i_valid, i_data} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, aborted, i_valid, i_data});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream(input string name, input logic [31:0] f, input logic [15:0] p,
                               input int c, input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e[4];
        logic [15:0] exp_a;
        int nw;
        int done_cyc;
        e = '{e0, e1, e2, e3};
        nw = 0;
        done_cyc = -1;
        for (int i = 0; i < c; i++) exp_q.push_back(e[i]);
        i_ready = 1'b1;
        do_start(f, p, 16'(c));
        for (int cyc = 1; cyc <= c + 4; cyc++) begin
            @(negedge clk);
            scramble_cfg();
            if (cyc <= c) begin
                n_cmp++;
                if (i_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s_valid_c%0d: got %b expected 1", name, cyc, i_valid);
                end
            end
            if (i_valid && i_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s_extra_word: got %h expected none", name, i_data);
                end else begin
                    exp_a = exp_q.pop_front();
                    if (i_data !== {exp_a, 16'h0}) begin
                        n_err++;
                        $display("FAIL %s_word%0d: got %h expected %h", name, nw, i_data,
                                 {exp_a, 16'h0});
                    end
                end
                nw++;
            end
            if (done && done_cyc < 0) begin
                done_cyc = cyc;
                n_cmp++;
                if (aborted !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_aborted: got %b expected 0", name, aborted);
                end
            end
        end
        n_cmp++;
        if (nw != c || done_cyc != c + 1) begin
            n_err++;
            $display("FAIL %s_count_done: got words=%0d done_cyc=%0d expected %0d/%0d",
                     name, nw, done_cyc, c, c + 1);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure;
        logic [3:0]  pat;
        logic [15:0] exp_a;
        logic [31:0] prev_data;
        logic        prev_stall;
        int nw, done_cyc, last_hs;
        pat = 4'b1001;
        nw = 0; done_cyc = -1; last_hs = -1; prev_stall = 1'b0; prev_data = '0;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h1000 + 16'(i));
        do_start(32'h0001_0000, 16'h1000, 16'd4);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            scramble_cfg();
            i_ready = pat[(cyc - 1) % 4];
            if (prev_stall) begin
                n_cmp++;
                if (i_valid !== 1'b1 || i_data !== prev_data) begin
                    n_err++;
                    $display("FAIL bp_hold_c%0d: got v=%b d=%h expected v=1 d=%h",
                             cyc, i_valid, i_data, prev_data);
                end
            end
            if (i_valid && i_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra_word: got %h expected none", i_data);
                end else begin
                    exp_a = exp_q.pop_front();
                    if (i_data !== {exp_a, 16'h0}) begin
                        n_err++;
                        $display("FAIL bp_word%0d: got %h expected %h", nw, i_data, {exp_a, 16'h0});
                    end
                end
                nw++;
                last_hs = cyc;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            prev_stall = i_valid && !i_ready;
            prev_data  = i_data;
        end
        n_cmp++;
        if (nw != 4 || last_hs != 8 || done_cyc != 9) begin
            n_err++;
            $display("FAIL bp_done: got words=%0d last_hs=%0d done=%0d expected 4/8/9",
                     nw, last_hs, done_cyc);
        end
        i_ready = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_count_zero;
        do_start(32'h0001_0000, 16'h1234, 16'd0);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            scramble_cfg();
            n_cmp++;
            if (i_valid !== 1'b0 || busy !== 1'b0 || done !== (cyc == 1)) begin
                n_err++;
                $display("FAIL zero_c%0d: got v=%b busy=%b done=%b expected 0/0/%b",
                         cyc, i_valid, busy, done, cyc == 1);
            end
        end
    endtask

    task automatic test_start_busy;
        logic [15:0] exp_a;
        int nw, done_cyc;
        nw = 0; done_cyc = -1;
        for (int i = 0; i < 3; i++) exp_q.push_back(16'h3000 + 16'(i));
        do_start(32'h0001_0000, 16'h3000, 16'd3);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            scramble_cfg();
            if (cyc == 2) begin
                start = 1'b1; cfg_count = 16'd7; cfg_phase0 = 16'h7777;
            end
            if (i_valid && i_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra_word: got %h expected none", i_data);
                end else begin
                    exp_a = exp_q.pop_front();
                    if (i_data !== {exp_a, 16'h0}) begin
                        n_err++;
                        $display("FAIL sb_word%0d: got %h expected %h", nw, i_data, {exp_a, 16'h0});
                    end
                end
                nw++;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
        end
        n_cmp++;
        if (nw != 3 || done_cyc != 4) begin
            n_err++;
            $display("FAIL sb_count: got words=%0d done=%0d expected 3/4", nw, done_cyc);
        end
        exp_q.delete();
    endtask

    // One abort burst: abort asserted at abort_cyc, i_ready low on the listed cycles.
    task automatic run_abort(input string name, input logic [15:0] p, input logic [15:0] c,
                             input int abort_cyc, input int stall_a, input int stall_b,
                             input int exp_words, input int exp_done, input logic exp_ab);
        logic [15:0] exp_a;
        int nw, done_cyc;
        nw = 0; done_cyc = -1;
        for (int i = 0; i < exp_words; i++) exp_q.push_back(p + 16'(i));
        do_start(32'h0001_0000, p, c);
        for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
            @(negedge clk);
            scramble_cfg();
            abort   = (cyc == abort_cyc);
            i_ready = !(cyc == stall_a || cyc == stall_b);
            if (i_valid && i_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s_extra_word: got %h expected none", name, i_data);
                end else begin
                    exp_a = exp_q.pop_front();
                    if (i_data !== {exp_a, 16'h0}) begin
                        n_err++;
                        $display("FAIL %s_word%0d: got %h expected %h", name, nw, i_data,
                                 {exp_a, 16'h0});
                    end
                end
                nw++;
            end
            if (done && done_cyc < 0) begin
                done_cyc = cyc;
                n_cmp++;
                if (aborted !== exp_ab) begin
                    n_err++;
                    $display("FAIL %s_aborted: got %b expected %b", name, aborted, exp_ab);
                end
            end
        end
        abort = 1'b0;
        i_ready = 1'b1;
        n_cmp++;
        if (nw != exp_words || done_cyc != exp_done || aborted !== exp_ab) begin
            n_err++;
            $display("FAIL %s_end: got words=%0d done=%0d ab=%b expected %0d/%0d/%b",
                     name, nw, done_cyc, aborted, exp_words, exp_done, exp_ab);
        end
        exp_q.delete();
    endtask

    task automatic test_abort;
        run_abort("abort_drain", 16'h2000, 16'd10, 4, 4, 5, 4, 7, 1'b1);
        run_abort("abort_last",  16'h4000, 16'd2,  2, 0, 0, 2, 3, 1'b0);
        run_abort("abort_hs",    16'h6000, 16'd5,  2, 0, 0, 2, 3, 1'b1);
    endtask

    task automatic test_rst_mid_burst;
        i_ready = 1'b1;
        do_start(32'h0001_0000, 16'h5000, 16'd10);
        repeat (3) begin
            @(negedge clk);
            scramble_cfg();
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, aborted, i_valid, i_data} !== 36'h0) begin
            n_err++;
            $display("FAIL rst_async: got %h expected 0", {busy, done, aborted, i_valid, i_data});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || i_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rst_quiet_c%0d: got done=%b v=%b busy=%b expected 0",
                         cyc, done, i_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream("basic", 32'h0001_0000, 16'h1000, 4, 16'h1000, 16'h1001, 16'h1002, 16'h1003);
        test_stream("wrap",  32'h0001_0000, 16'hFFFF, 3, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000);
        test_stream("frac",  32'h0000_8000, 16'h0000, 4, 16'h0000, 16'h0000, 16'h0001, 16'h0001);
        test_backpressure();
        test_count_zero();
        test_start_busy();
        test_abort();
        test_rst_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
